seq_divider32: RTL and testbench

//  Iterative radix-2 restoring divider; the inverse companion of the 32-bit sequential multiplier.

---
 rtl/seq_divider32.sv | 162 ++++++++++++++++
 tb/tb_seq_divider32.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32.sv
// ---------------------------------------------------------------------------
// seq_divider32
//   Iterative radix-2 restoring divider. Operands are converted to unsigned
//   magnitudes when accepted, one quotient bit is produced per cycle MSB
//   first, and signs are re-applied in a two-cycle FIX phase before the
//   results are published together with a one-cycle done pulse.
//
//   Optional feature macro: DIV_EARLY_EXIT_EN
//     When defined, an operation whose divisor magnitude is zero or larger
//     than the dividend magnitude skips the iteration phase entirely.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request, sampled only while idle
//   in0          dividend
//   in1          divisor
//   sign_en_in0  1: in0 is two's complement, 0: unsigned
//   sign_en_in1  1: in1 is two's complement, 0: unsigned
//   busy         high from the cycle after acceptance until done
//   done         one-cycle pulse, results valid
//   quotient     result quotient, held between operations
//   remainder    result remainder (sign of dividend), held
//   div_by_zero  set with done when divisor was zero, held
// ---------------------------------------------------------------------------
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sign_en_in0,
  input  logic             sign_en_in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;     // dividend shifter, becomes the quotient
  logic [WIDTH-1:0] dsr;     // divisor magnitude
  logic [WIDTH-1:0] rem;     // partial remainder
  logic [WIDTH-1:0] raw0;    // original dividend, returned on divide by zero
  logic             neg0_r;
  logic             neg1_r;
  logic             dz_r;
  logic             fix_ph;

  logic             neg0;
  logic             neg1;
  logic [WIDTH-1:0] mag0;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Negating the most negative value yields the same bit pattern, which is
  // exactly its magnitude when read as unsigned.
  assign neg0 = sign_en_in0 & in0[WIDTH-1];
  assign neg1 = sign_en_in1 & in1[WIDTH-1];
  assign mag0 = neg0 ? (~in0 + 1'b1) : in0;
  assign mag1 = neg1 ? (~in1 + 1'b1) : in1;

  // Shift the next dividend bit into the remainder; the extra top bit keeps
  // the comparison exact. The subtraction result always fits in WIDTH bits.
  assign trial = {rem, dvd[WIDTH-1]};
  assign ge    = trial >= {1'b0, dsr};
  assign diff  = trial[WIDTH-1:0] - dsr;

`ifdef DIV_EARLY_EXIT_EN
  logic early;
  assign early = (mag1 == '0) || (mag0 < mag1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      raw0        <= '0;
      neg0_r      <= 1'b0;
      neg1_r      <= 1'b0;
      dz_r        <= 1'b0;
      fix_ph      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is deliberately dropped.
          if (start && !done) begin
            raw0   <= in0;
            neg0_r <= neg0;
            neg1_r <= neg1;
            dz_r   <= (in1 == '0);
            dvd    <= mag0;
            dsr    <= mag1;
            rem    <= '0;
            cnt    <= '0;
            fix_ph <= 1'b0;
            busy   <= 1'b1;
            state  <= CALC;
`ifdef DIV_EARLY_EXIT_EN
            if (early) begin
              dvd   <= '0;
              rem   <= mag0;
              state <= FIX;
            end
`endif
          end
        end

        CALC: begin
          rem <= ge ? diff : trial[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end

        FIX: begin
          if (!fix_ph) begin
            // First cycle: restore signs in place (or force the /0 results).
            fix_ph <= 1'b1;
            if (dz_r) begin
              dvd <= '1;
              rem <= raw0;
            end else begin
              if (neg0_r ^ neg1_r) dvd <= ~dvd + 1'b1;
              if (neg0_r)          rem <= ~rem + 1'b1;
            end
          end else begin
            // Second cycle: publish.
            quotient    <= dvd;
            remainder   <= rem;
            div_by_zero <= dz_r;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// ---------------------------------------------------------------------------
// tb_seq_divider32
//   Directed bench for seq_divider32. Each accepted operation pushes its
//   expected result into a scoreboard queue; the entry is popped and
//   compared when done is observed.
// ---------------------------------------------------------------------------
module tb_seq_divider32;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in0 = '0;
  logic [W-1:0] in1 = '0;
  logic         sign_en_in0 = 1'b0;
  logic         sign_en_in1 = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_divider32 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in0         (in0),
    .in1         (in1),
    .sign_en_in0 (sign_en_in0),
    .sign_en_in1 (sign_en_in1),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: 64-bit signed arithmetic truncates toward zero and
  // gives the remainder the dividend's sign.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sa, input logic sb_);
    exp_t   e;
    longint la, lb, lq, lr;
    longint ma, mb;
    la = sa  ? longint'($signed(a)) : longint'({32'd0, a});
    lb = sb_ ? longint'($signed(b)) : longint'({32'd0, b});
    ma = (la < 0) ? -la : la;
    mb = (lb < 0) ? -lb : lb;
    if (lb == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      lq   = la / lb;
      lr   = la % lb;
      e.q  = lq[W-1:0];
      e.r  = lr[W-1:0];
      e.dz = 1'b0;
    end
    e.lat = W + 2;
`ifdef DIV_EARLY_EXIT_EN
    if (mb == 0 || ma < mb) e.lat = 2;
`endif
    return e;
  endfunction

  // Accept one operation; returns after the accepting edge with start low
  // and the operand buses scrambled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb_, input bit push);
    in0 = a; in1 = b; sign_en_in0 = sa; sign_en_in1 = sb_;
    start = 1'b1;
    if (push) sb.push_back(model(a, b, sa, sb_));
    @(posedge clk); #1;
    start = 1'b0;
    in0 = $urandom; in1 = $urandom;
    sign_en_in0 = 1'b0; sign_en_in1 = 1'b0;
  endtask

  // Wait for done; 'elapsed' is edges already consumed since acceptance.
  task automatic wait_done(input string tag, input int elapsed, input bit poke_in_done);
    int   k = elapsed;
    bit   seen = 0;
    exp_t e;
    while (k < 200 && !seen) begin
      @(posedge clk); #1;
      k++;
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 64'(k), 64'(e.lat));
    check({tag, "_q"}, 64'(quotient), 64'(e.q));
    check({tag, "_r"}, 64'(remainder), 64'(e.r));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(e.dz));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    if (poke_in_done) begin
      in0 = 32'd77; in1 = 32'd7; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    if (poke_in_done) check({tag, "_start_in_done_ignored"}, 64'(busy), 64'd0);
  endtask

  task automatic no_done_for(input string tag, input int n);
    bit spurious = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) spurious = 1;
    end
    check({tag, "_no_done"}, 64'(spurious), 64'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1. unsigned 100/7, plus start during the done cycle
    issue(32'd100, 32'd7, 1'b0, 1'b0, 1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 0, 1);

    // 2. signed -100/7
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 1);
    wait_done("t2", 0, 0);

    // 3. most negative / -1, signed then unsigned
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);
    wait_done("t3s", 0, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    wait_done("t3u", 0, 0);

    // 4. divide by zero, both sign modes, and a negative dividend
    issue(32'd5, 32'd0, 1'b0, 1'b0, 1);
    wait_done("t4u", 0, 0);
    issue(32'd5, 32'd0, 1'b1, 1'b1, 1);
    wait_done("t4s", 0, 0);
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 1);
    wait_done("t4n", 0, 0);

    // Mixed signs
    issue(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1, 1);
    wait_done("mix", 0, 0);
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 1);
    wait_done("mix2", 0, 0);

    // 5. start pulsed at N+5 while busy with new operands
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    in0 = 32'd2; in1 = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 5, 0);
    no_done_for("t5_second", 40);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // 6. reset at N+10 aborts the operation
    issue(32'd1234, 32'd5, 1'b0, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_q", 64'(quotient), 64'd0);
    check("t6_r", 64'(remainder), 64'd0);
    check("t6_dz", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    no_done_for("t6_abort", 40);
    issue(32'd9, 32'd3, 1'b0, 1'b0, 1);
    wait_done("t6_after", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
